// File: rtl/alu_rs.sv
// Reservation station for the ALU: captures operands from both CDB ports and issues the lowest ready entry.
// Issue registered one edge after readiness; a dispatch while full is dropped, and rdy_in low freezes all state.
module alu_rs #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [5:0]       disp_type,
  input  logic             disp_qj_busy,
  input  logic             disp_qk_busy,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_pc,
  input  logic [ROB_W-1:0] disp_rob_pos,
  input  logic             cdb0_valid,
  input  logic [ROB_W-1:0] cdb0_tag,
  input  logic [31:0]      cdb0_val,
  input  logic             cdb1_valid,
  input  logic [ROB_W-1:0] cdb1_tag,
  input  logic [31:0]      cdb1_val,
  output logic             full,
  output logic             alu_todo,
  output logic [5:0]       alu_type,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [ROB_W-1:0] alu_rob_pos
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             busy;
    logic [ROB_W-1:0] tag;
    logic [31:0]      val;
  } opnd_t;

  typedef struct packed {
    logic             busy;
    logic [5:0]       typ;
    opnd_t            j;
    opnd_t            k;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [ROB_W-1:0] rob_pos;
  } ent_t;

  ent_t             ent [DEPTH];
  ent_t             disp_ent;
  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             free_ok;
  logic             sel_ok;

  // Port 0 wins when both ports carry the operand's tag.
  function automatic opnd_t snoop(input opnd_t o);
    opnd_t r;
    r = o;
    if (o.busy && cdb0_valid && cdb0_tag == o.tag) begin
      r.busy = 1'b0;
      r.val  = cdb0_val;
    end else if (o.busy && cdb1_valid && cdb1_tag == o.tag) begin
      r.busy = 1'b0;
      r.val  = cdb1_val;
    end
    return r;
  endfunction

  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy && !ent[i].j.busy && !ent[i].k.busy;
    end
  end

  // Scanning downward leaves the lowest matching index in place.
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    sel_ok   = 1'b0;
    sel_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_vec[i]) begin
        free_ok  = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ready_vec[i]) begin
        sel_ok  = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign full = &busy_vec;

  always_comb begin
    disp_ent         = '0;
    disp_ent.busy    = 1'b1;
    disp_ent.typ     = disp_type;
    disp_ent.j       = snoop('{busy: disp_qj_busy, tag: disp_qj, val: disp_vj});
    disp_ent.k       = snoop('{busy: disp_qk_busy, tag: disp_qk, val: disp_vk});
    disp_ent.imm     = disp_imm;
    disp_ent.pc      = disp_pc;
    disp_ent.rob_pos = disp_rob_pos;
  end

  // Free slot is chosen from registered busy bits, so the entry issued this cycle is never reused until next cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      alu_todo    <= 1'b0;
      alu_type    <= '0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
        alu_todo <= 1'b0;
      end else begin
        alu_todo <= sel_ok;
        if (sel_ok) begin
          alu_type    <= ent[sel_idx].typ;
          alu_val1    <= ent[sel_idx].j.val;
          alu_val2    <= ent[sel_idx].k.val;
          alu_imm     <= ent[sel_idx].imm;
          alu_pc      <= ent[sel_idx].pc;
          alu_rob_pos <= ent[sel_idx].rob_pos;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (sel_ok && sel_idx == IDX_W'(i)) begin
            ent[i].busy <= 1'b0;
          end else if (disp_valid && free_ok && free_idx == IDX_W'(i)) begin
            ent[i] <= disp_ent;
          end else if (ent[i].busy) begin
            ent[i].j <= snoop(ent[i].j);
            ent[i].k <= snoop(ent[i].k);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: literal expectations per scenario plus a per-cycle reference model.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        disp_valid, disp_qj_busy, disp_qk_busy;
  logic [5:0]  disp_type;
  logic [4:0]  disp_qj, disp_qk, disp_rob_pos;
  logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc;
  logic        cdb0_valid, cdb1_valid;
  logic [4:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_val, cdb1_val;
  logic        full, alu_todo;
  logic [5:0]  alu_type;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [4:0]  alu_rob_pos;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  alu_rs #(.DEPTH(8), .ROB_W(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .disp_valid(disp_valid), .disp_type(disp_type),
    .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_pos(disp_rob_pos),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
    .full(full), .alu_todo(alu_todo), .alu_type(alu_type),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a table of slots plus the expected issue-port contents.
  bit          m_busy [8];
  logic [5:0]  m_type [8];
  bit          m_jb [8], m_kb [8];
  logic [4:0]  m_jt [8], m_kt [8], m_rob [8];
  logic [31:0] m_jv [8], m_kv [8], m_imm [8], m_pc [8];
  bit          e_todo = 1'b0;
  logic [5:0]  e_type = '0;
  logic [31:0] e_v1 = '0, e_v2 = '0, e_imm = '0, e_pc = '0;
  logic [4:0]  e_rob = '0;

  function automatic logic [32:0] resolve(input bit b, input logic [4:0] t, input logic [31:0] v);
    if (b && cdb0_valid && cdb0_tag == t) return {1'b0, cdb0_val};
    if (b && cdb1_valid && cdb1_tag == t) return {1'b0, cdb1_val};
    return {b, v};
  endfunction

  always @(posedge clk_in) begin
    int pick;
    int slot;
    logic [32:0] r;
    pick = -1;
    slot = -1;
    if (rst_in) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      e_todo = 1'b0; e_type = '0; e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_rob = '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
        e_todo = 1'b0;
      end else begin
        for (int i = 7; i >= 0; i--) begin
          if (m_busy[i] && !m_jb[i] && !m_kb[i]) pick = i;
          if (!m_busy[i]) slot = i;
        end
        e_todo = (pick >= 0);
        if (pick >= 0) begin
          e_type = m_type[pick]; e_v1 = m_jv[pick]; e_v2 = m_kv[pick];
          e_imm = m_imm[pick]; e_pc = m_pc[pick]; e_rob = m_rob[pick];
          m_busy[pick] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          if (m_busy[i]) begin
            r = resolve(m_jb[i], m_jt[i], m_jv[i]); m_jb[i] = r[32]; m_jv[i] = r[31:0];
            r = resolve(m_kb[i], m_kt[i], m_kv[i]); m_kb[i] = r[32]; m_kv[i] = r[31:0];
          end
        end
        if (disp_valid && slot >= 0) begin
          m_busy[slot] = 1'b1; m_type[slot] = disp_type;
          m_jt[slot] = disp_qj; m_kt[slot] = disp_qk;
          r = resolve(disp_qj_busy, disp_qj, disp_vj); m_jb[slot] = r[32]; m_jv[slot] = r[31:0];
          r = resolve(disp_qk_busy, disp_qk, disp_vk); m_kb[slot] = r[32]; m_kv[slot] = r[31:0];
          m_imm[slot] = disp_imm; m_pc[slot] = disp_pc; m_rob[slot] = disp_rob_pos;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (started) begin
      chk("model_full", 32'(full), 32'(m_busy.and()));
      chk("model_todo", 32'(alu_todo), 32'(e_todo));
      chk("model_type", 32'(alu_type), 32'(e_type));
      chk("model_val1", alu_val1, e_v1);
      chk("model_val2", alu_val2, e_v2);
      chk("model_imm", alu_imm, e_imm);
      chk("model_pc", alu_pc, e_pc);
      chk("model_rob", 32'(alu_rob_pos), 32'(e_rob));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_in();
    disp_valid = 1'b0; cdb0_valid = 1'b0; cdb1_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic put(input logic [5:0] t, input bit jb, input logic [4:0] j, input logic [31:0] vj,
                     input bit kb, input logic [4:0] k, input logic [31:0] vk, input logic [4:0] rob);
    disp_valid = 1'b1; disp_type = t;
    disp_qj_busy = jb; disp_qj = j; disp_vj = vj;
    disp_qk_busy = kb; disp_qk = k; disp_vk = vk;
    disp_rob_pos = rob; disp_imm = 32'h1000 + 32'(rob); disp_pc = 32'h4000 + 32'(rob) * 4;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    idle_in();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    disp_valid = 1'b0;
    cdb0_tag = '0; cdb0_val = '0; cdb1_tag = '0; cdb1_val = '0;
    tick(); tick();
    rst_in = 1'b0;
    started = 1'b1;
    chk("reset_todo", 32'(alu_todo), 0);
    chk("reset_full", 32'(full), 0);
    chk("reset_val1", alu_val1, 0);
    chk("reset_rob", 32'(alu_rob_pos), 0);

    // Ready ADD issues two edges after dispatch.
    put(27, 0, 0, 5, 0, 0, 7, 3);
    tick(); idle_in();
    chk("add_no_early", 32'(alu_todo), 0);
    tick();
    chk("add_todo", 32'(alu_todo), 1);
    chk("add_type", 32'(alu_type), 27);
    chk("add_val1", alu_val1, 5);
    chk("add_val2", alu_val2, 7);
    chk("add_rob", 32'(alu_rob_pos), 3);
    tick();
    chk("add_pulse", 32'(alu_todo), 0);

    // Pending operand woken by cdb1.
    put(19, 1, 4, 0, 0, 0, 32'h11, 6);
    tick(); idle_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("addi_wait", 32'(alu_todo), 0);
    end
    cdb1_valid = 1'b1; cdb1_tag = 4; cdb1_val = 32'h100;
    tick(); idle_in();
    chk("addi_not_yet", 32'(alu_todo), 0);
    tick();
    chk("addi_todo", 32'(alu_todo), 1);
    chk("addi_val1", alu_val1, 32'h100);
    chk("addi_val2", alu_val2, 32'h11);
    tick();

    // Wakeup during the dispatch cycle itself.
    put(27, 1, 9, 0, 0, 0, 1, 8);
    cdb0_valid = 1'b1; cdb0_tag = 9; cdb0_val = 32'hAB;
    tick(); idle_in();
    tick();
    chk("same_todo", 32'(alu_todo), 1);
    chk("same_val1", alu_val1, 32'hAB);
    tick();

    // Fill, overflow dispatch, then simultaneous wakeup of entries 5 and 2.
    for (int i = 0; i < 8; i++) begin
      put(27, 1, 5'(10 + i), 0, 0, 0, 32'(i), 5'(20 + i));
      tick();
    end
    idle_in();
    chk("fill_full", 32'(full), 1);
    put(27, 0, 0, 32'hDEAD, 0, 0, 1, 30);
    tick(); idle_in();
    tick();
    chk("ovf_no_issue", 32'(alu_todo), 0);
    chk("ovf_full", 32'(full), 1);
    cdb0_valid = 1'b1; cdb0_tag = 15; cdb0_val = 32'h55;
    cdb1_valid = 1'b1; cdb1_tag = 12; cdb1_val = 32'h22;
    tick(); idle_in();
    chk("wake_not_yet", 32'(alu_todo), 0);
    tick();
    chk("first_todo", 32'(alu_todo), 1);
    chk("first_rob", 32'(alu_rob_pos), 22);
    chk("first_val1", alu_val1, 32'h22);
    chk("first_full", 32'(full), 0);
    tick();
    chk("second_todo", 32'(alu_todo), 1);
    chk("second_rob", 32'(alu_rob_pos), 25);
    chk("second_val1", alu_val1, 32'h55);
    tick();
    chk("second_pulse", 32'(alu_todo), 0);

    // Three ready entries, then flush.
    cdb0_valid = 1'b1; cdb0_tag = 10; cdb0_val = 32'h1;
    cdb1_valid = 1'b1; cdb1_tag = 11; cdb1_val = 32'h2;
    put(27, 0, 0, 32'h77, 0, 0, 32'h88, 9);
    tick(); idle_in();
    flush = 1'b1;
    tick(); idle_in();
    chk("flush_todo", 32'(alu_todo), 0);
    chk("flush_full", 32'(full), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_quiet", 32'(alu_todo), 0);
    end

    // Stall with rdy_in low; inputs during the stall are dropped.
    put(36, 0, 0, 32'h1234, 0, 0, 32'h5678, 7);
    tick(); idle_in();
    rdy_in = 1'b0;
    put(27, 0, 0, 32'hBAD, 0, 0, 32'hBAD, 11);
    cdb0_valid = 1'b1; cdb0_tag = 0; cdb0_val = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_todo", 32'(alu_todo), 0);
    end
    idle_in();
    rdy_in = 1'b1;
    tick();
    chk("stall_todo_after", 32'(alu_todo), 1);
    chk("stall_type", 32'(alu_type), 36);
    chk("stall_val1", alu_val1, 32'h1234);
    chk("stall_val2", alu_val2, 32'h5678);
    chk("stall_rob", 32'(alu_rob_pos), 7);
    tick();
    chk("stall_drop", 32'(alu_todo), 0);
    chk("stall_empty", 32'(full), 0);

    // Reset with pending work clears entries and outputs.
    put(1, 0, 0, 32'hA, 0, 0, 0, 1);
    tick();
    put(2, 0, 0, 32'hB, 0, 0, 0, 2);
    tick(); idle_in();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rst_todo", 32'(alu_todo), 0);
    chk("rst_val1", alu_val1, 0);
    chk("rst_rob", 32'(alu_rob_pos), 0);
    tick();
    chk("rst_no_issue", 32'(alu_todo), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
